// File: rtl/collector_pkg.sv
// Shared types for the result collector: FSM states and the record handed to the frame builder.
package collector_pkg;

    typedef enum logic [1:0] {
        SCAN,
        SHIFT,
        HOLD
    } state_t;

    localparam int MAX_CH_W      = 6;
    localparam int MAX_WORD_BITS = 64;

    // Widest record any collector instance can emit; narrower instances use the low bits.
    typedef struct packed {
        logic [MAX_CH_W-1:0]      ch;
        logic [MAX_WORD_BITS-1:0] word;
        logic                     oflow;
        logic                     err;
    } record_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first asserted request after index 'last', wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int c;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        // k = N revisits 'last' itself, so a lone requester is served back-to-back.
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Round-robin harvester: serially pops one word from an eligible channel FIFO and offers it as a record.
module result_collector
    import collector_pkg::*;
#(
    parameter int N_CH      = 24,
    parameter int WORD_BITS = 32,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      ch_enable,
    input  logic [N_CH-1:0]      fifo_empty,
    input  logic [N_CH-1:0]      fifo_oflow,
    output logic [N_CH-1:0]      fifo_req,
    input  logic [N_CH-1:0]      fifo_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [WORD_BITS-1:0] out_word,
    output logic                 out_oflow,
    output logic                 out_err,
    output logic                 busy
);

    localparam int              CNT_W    = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

    state_t               state;
    state_t               state_next;
    logic [CH_W-1:0]      sel;
    logic [CH_W-1:0]      rr_last;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_BITS-1:0] shreg;
    logic                 err;
    logic [N_CH-1:0]      oflow_s;
    logic [N_CH-1:0]      oflow_clr;
    logic [N_CH-1:0]      eligible;
    logic                 pick_valid;
    logic [CH_W-1:0]      pick_idx;
    logic                 accept;

    assign eligible = ch_enable & ~fifo_empty;

    rr_pick #(
        .N     (N_CH),
        .IDX_W (CH_W)
    ) u_pick (
        .req   (eligible),
        .last  (rr_last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next = state;
        fifo_req   = '0;
        accept     = 1'b0;
        oflow_clr  = '0;
        case (state)
            SCAN: begin
                if (pick_valid) state_next = SHIFT;
            end
            SHIFT: begin
                fifo_req[sel] = 1'b1;
                if (cnt == LAST_BIT) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    accept         = 1'b1;
                    oflow_clr[sel] = 1'b1;
                    state_next     = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            sel     <= '0;
            rr_last <= CH_W'(N_CH - 1);
            cnt     <= '0;
            shreg   <= '0;
            err     <= 1'b0;
            oflow_s <= '0;
        end else begin
            state <= state_next;
            case (state)
                SCAN: begin
                    if (pick_valid) begin
                        sel   <= pick_idx;
                        shreg <= '0;
                        err   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // Bits are kept as sampled even on underrun; err flags the record instead.
                    shreg[cnt] <= fifo_bits[sel];
                    if (fifo_empty[sel]) err <= 1'b1;
                    if (cnt == LAST_BIT) begin
                        cnt     <= '0;
                        rr_last <= sel;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // A new overflow arriving with acceptance survives into the next record.
            oflow_s <= (oflow_s & ~oflow_clr) | fifo_oflow;
        end
    end

    assign out_valid = (state == HOLD);
    assign out_ch    = sel;
    assign out_word  = shreg;
    assign out_err   = err;
    assign out_oflow = (state == HOLD) && oflow_s[sel];
    assign busy      = (state != SCAN);

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector (N_CH=4, WORD_BITS=8): FIFO model, record scoreboard, table and random runs.
`timescale 1ns/1ps
module tb_result_collector;
    import collector_pkg::*;

    localparam int N  = 4;
    localparam int WB = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  ch_enable = '0;
    logic [N-1:0]  fifo_empty;
    logic [N-1:0]  fifo_oflow = '0;
    logic [N-1:0]  fifo_req;
    logic [N-1:0]  fifo_bits;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ch;
    logic [WB-1:0] out_word;
    logic          out_oflow;
    logic          out_err;
    logic          busy;

    always #5 clk = ~clk;

    result_collector #(.N_CH(N), .WORD_BITS(WB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_enable  (ch_enable),
        .fifo_empty (fifo_empty),
        .fifo_oflow (fifo_oflow),
        .fifo_req   (fifo_req),
        .fifo_bits  (fifo_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_word   (out_word),
        .out_oflow  (out_oflow),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Channel FIFO model: words stored whole, shifted out LSB first while req is high.
    logic [WB-1:0] mem [N][64];
    int            wr [N];
    int            rd [N];
    int            bpos [N];
    logic [N-1:0]  force_empty = '0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (rd[i] >= wr[i]) || force_empty[i];
            fifo_bits[i]  = mem[i][rd[i] % 64][bpos[i] % WB];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                rd[i]   <= 0;
                bpos[i] <= 0;
            end else if (fifo_req[i]) begin
                if (bpos[i] == WB - 1) begin
                    bpos[i] <= 0;
                    rd[i]   <= rd[i] + 1;
                end else begin
                    bpos[i] <= bpos[i] + 1;
                end
            end
        end
    end

    int      checks = 0;
    int      errors = 0;
    record_t exp_q[$];
    int      rise_q[$];
    int      req_hist [N];
    int      cyc = 0;
    logic    prev_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic record_t mk(input int c, input logic [WB-1:0] w, input logic of, input logic er);
        record_t r;
        r       = '0;
        r.ch    = MAX_CH_W'(c);
        r.word  = MAX_WORD_BITS'(w);
        r.oflow = of;
        r.err   = er;
        return r;
    endfunction

    // Monitor: invariants every cycle, scoreboard on each accepted record.
    initial begin
        record_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                cyc++;
                chk("req_onehot", 64'($countones(fifo_req) <= 1), 64'(1));
                chk("busy", 64'(busy), 64'((fifo_req != '0) || out_valid));
                for (int i = 0; i < N; i++) if (fifo_req[i]) req_hist[i]++;
                if (out_valid && !prev_valid) rise_q.push_back(cyc);
                prev_valid = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_record: got ch=%0d word=%0h, expected none", out_ch, out_word);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rec_ch", 64'(out_ch), 64'(e.ch));
                        chk("rec_word", 64'(out_word), e.word);
                        chk("rec_oflow", 64'(out_oflow), 64'(e.oflow));
                        chk("rec_err", 64'(out_err), 64'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_phase(input logic [N-1:0] en);
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        fifo_oflow  = '0;
        force_empty = '0;
        ch_enable   = en;
        exp_q.delete();
        rise_q.delete();
        for (int i = 0; i < N; i++) begin
            wr[i]       = 0;
            req_hist[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [WB-1:0] w);
        mem[c][wr[c]] = w;
        wr[c]++;
    endtask

    task automatic wait_drain(input int maxc, input bit rnd_ready);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d records outstanding, expected 0", exp_q.size());
        end
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (!out_valid && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_valid", 64'(out_valid), 64'(1));
    endtask

    function automatic logic [WB-1:0] wv(input int c, input int k);
        return WB'(8'h5A + 8'h31 * c + 8'h0F * k);
    endfunction

    // Round-robin reference: plain walk over remaining word counts.
    int            cnt_m [N];
    logic [WB-1:0] w_m [N][4];

    task automatic model_rr(input logic [N-1:0] en);
        int taken [N];
        int last;
        int found;
        int c;
        last = N - 1;
        for (int i = 0; i < N; i++) taken[i] = 0;
        forever begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                c = (last + k) % N;
                if (found < 0 && en[c] && taken[c] < cnt_m[c]) found = c;
            end
            if (found < 0) break;
            exp_q.push_back(mk(found, w_m[found][taken[found]], 1'b0, 1'b0));
            taken[found]++;
            last = found;
        end
    endtask

    typedef struct packed {
        logic [3:0]  en;
        logic [15:0] cnt;
        logic [31:0] order;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [N-1:0]  en;
        logic [CW-1:0] s_ch;
        logic [WB-1:0] s_word;
        int            occ [N];
        int            nexp;
        int            c;

        vecs[0] = '{en: 4'b1111, cnt: 16'h1112, order: 32'h01230FFF};
        vecs[1] = '{en: 4'b1011, cnt: 16'h1112, order: 32'h0130FFFF};
        vecs[2] = '{en: 4'b1111, cnt: 16'h0300, order: 32'h222FFFFF};
        vecs[3] = '{en: 4'b0110, cnt: 16'h2222, order: 32'h1212FFFF};
        vecs[4] = '{en: 4'b1111, cnt: 16'h2002, order: 32'h0303FFFF};
        vecs[5] = '{en: 4'b1101, cnt: 16'h0111, order: 32'h02FFFFFF};

        // Reset state, then ch2 holding 0xA5 with exact request window and latency.
        start_phase(4'b1111);
        push(2, 8'hA5);
        exp_q.push_back(mk(2, 8'hA5, 1'b0, 1'b0));
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_req", 64'(fifo_req), 64'(0));
        chk("rst_ch", 64'(out_ch), 64'(0));
        chk("rst_word", 64'(out_word), 64'(0));
        chk("rst_flags", 64'({out_oflow, out_err, busy}), 64'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                chk("a5_req", 64'(fifo_req), 64'(4'b0100));
                chk("a5_valid_low", 64'(out_valid), 64'(0));
            end else begin
                chk("a5_req_off", 64'(fifo_req), 64'(0));
                chk("a5_valid", 64'(out_valid), 64'(1));
                chk("a5_ch", 64'(out_ch), 64'(2));
                chk("a5_word", 64'(out_word), 64'(8'hA5));
            end
        end
        wait_drain(50, 1'b0);

        // Table: enable mask and per-channel fill versus expected service order.
        for (int v = 0; v < 6; v++) begin
            start_phase(vecs[v].en);
            for (int i = 0; i < N; i++) begin
                occ[i] = 0;
                for (int k = 0; k < int'(vecs[v].cnt[4*i +: 4]); k++) push(i, wv(i, k));
            end
            nexp = 0;
            for (int k = 0; k < 8; k++) begin
                c = int'(vecs[v].order[31 - 4*k -: 4]);
                if (c < N && nexp == k) begin
                    exp_q.push_back(mk(c, wv(c, occ[c]), 1'b0, 1'b0));
                    occ[c]++;
                    nexp++;
                end
            end
            rst_n     = 1'b1;
            out_ready = 1'b1;
            wait_drain(200, 1'b0);
            chk("tbl_nrec", 64'(rise_q.size()), 64'(nexp));
            for (int i = 1; i < rise_q.size(); i++) chk("tbl_gap", 64'(rise_q[i] - rise_q[i-1]), 64'(10));
            for (int i = 0; i < N; i++) chk("tbl_req_hist", 64'(req_hist[i]), 64'(WB * occ[i]));
        end

        // Stall: record held stable 20 cycles, no new request while waiting.
        start_phase(4'b1111);
        push(1, 8'h3C);
        push(3, 8'hC3);
        exp_q.push_back(mk(1, 8'h3C, 1'b0, 1'b0));
        exp_q.push_back(mk(3, 8'hC3, 1'b0, 1'b0));
        rst_n = 1'b1;
        wait_valid(20);
        s_ch   = out_ch;
        s_word = out_word;
        chk("stall_ch0", 64'(s_ch), 64'(1));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_ch", 64'(out_ch), 64'(s_ch));
            chk("stall_word", 64'(out_word), 64'(s_word));
            chk("stall_req", 64'(fifo_req), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain(50, 1'b0);

        // Overflow pulse on ch1 while ch0 is being shifted.
        start_phase(4'b0011);
        push(0, 8'h11); push(0, 8'h22); push(1, 8'h33); push(1, 8'h44);
        exp_q.push_back(mk(0, 8'h11, 1'b0, 1'b0));
        exp_q.push_back(mk(1, 8'h33, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 8'h22, 1'b0, 1'b0));
        exp_q.push_back(mk(1, 8'h44, 1'b0, 1'b0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        fifo_oflow = 4'b0010;
        @(posedge clk);
        #1;
        fifo_oflow = '0;
        wait_drain(100, 1'b0);

        // Overflow pulse coinciding with acceptance stays set for the next record.
        start_phase(4'b0010);
        push(1, 8'h55); push(1, 8'h66); push(1, 8'h77);
        exp_q.push_back(mk(1, 8'h55, 1'b1, 1'b0));
        exp_q.push_back(mk(1, 8'h66, 1'b1, 1'b0));
        exp_q.push_back(mk(1, 8'h77, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        fifo_oflow = 4'b0010;
        @(posedge clk);
        #1;
        fifo_oflow = '0;
        wait_valid(20);
        out_ready  = 1'b1;
        fifo_oflow = 4'b0010;
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        fifo_oflow = '0;
        wait_valid(20);
        out_ready = 1'b1;
        wait_drain(100, 1'b0);

        // Underrun at bit 3: full shift still runs, err only on that record.
        start_phase(4'b0001);
        push(0, 8'h96); push(0, 8'h69);
        exp_q.push_back(mk(0, 8'h96, 1'b0, 1'b1));
        exp_q.push_back(mk(0, 8'h69, 1'b0, 1'b0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        force_empty = 4'b0001;
        @(posedge clk);
        #1;
        force_empty = '0;
        wait_drain(100, 1'b0);
        chk("underrun_req_cycles", 64'(req_hist[0]), 64'(2 * WB));

        // Random fills, masks and consumer stalls against the round-robin reference.
        for (int it = 0; it < 20; it++) begin
            en = N'($urandom);
            start_phase(en);
            for (int i = 0; i < N; i++) begin
                cnt_m[i] = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) w_m[i][k] = WB'($urandom);
                for (int k = 0; k < cnt_m[i]; k++) push(i, w_m[i][k]);
            end
            model_rr(en);
            rst_n = 1'b1;
            wait_drain(400, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
